// File: rtl/snn_pkg.sv
// Shared definitions for the spike/AER blocks: address-width helper, default
// counter width and the address-event record.
package snn_pkg;

   // $clog2 returns 0 for a single entry; an address bus is never narrower than 1 bit.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int NUM_CH_DEF = 8;
   localparam int DROP_W_DEF = 16;
   localparam int ADDR_W_DEF = clog2_safe(NUM_CH_DEF);

   typedef struct packed {
      logic                  valid;
      logic [ADDR_W_DEF-1:0] addr;
   } aer_event_t;

endpackage

// File: rtl/spike_aer_arbiter_if.sv
// AER output stream. An event transfers on a rising edge where aer_valid and
// aer_ready are both high; once raised, aer_valid and aer_addr hold until that transfer.
interface spike_aer_arbiter_if #(
   parameter int ADDR_W = 3
) ();

   logic              aer_valid;
   logic [ADDR_W-1:0] aer_addr;
   logic              aer_ready;

   modport master (
      output aer_valid,
      output aer_addr,
      input  aer_ready
   );

   modport slave (
      input  aer_valid,
      input  aer_addr,
      output aer_ready
   );

endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin find-first: returns the first set request at or
// after ptr, wrapping from NUM_CH-1 back to 0.
module rr_priority_select #(
   parameter int NUM_CH = 8,
   parameter int ADDR_W = 3
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [ADDR_W-1:0] ptr,
   output logic              gnt_valid,
   output logic [ADDR_W-1:0] gnt_idx
);

   // Scan from the farthest offset down so the nearest hit is written last and wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int off = NUM_CH - 1; off >= 0; off--) begin
         int                cand;
         logic [ADDR_W-1:0] cand_idx;
         cand = int'(ptr) + off;
         if (cand >= NUM_CH) begin
            cand = cand - NUM_CH;
         end
         cand_idx = ADDR_W'(cand);
         if (req[cand_idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/spike_aer_arbiter.sv
// Merges NUM_CH single-cycle spike trains into one AER valid/ready stream with
// one pending event per channel, round-robin grant and a saturating drop counter.
module spike_aer_arbiter
   import snn_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int ADDR_W = clog2_safe(NUM_CH),
   parameter int DROP_W = DROP_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [NUM_CH-1:0]   spike_in,
   spike_aer_arbiter_if.master aer,
   output logic                drop_pulse,
   output logic [DROP_W-1:0]   drop_count,
   output logic                busy
);

   // Wide enough to hold the counter maximum plus NUM_CH drops without wrapping.
   localparam int                SUM_W    = DROP_W + ADDR_W + 1;
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   logic [NUM_CH-1:0] pending_q;
   logic [NUM_CH-1:0] pending_d;
   logic [NUM_CH-1:0] spike_en;
   logic [NUM_CH-1:0] gnt_mask;
   logic [NUM_CH-1:0] drop_vec;
   logic              out_valid_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [ADDR_W-1:0] rr_ptr_q;
   logic [ADDR_W-1:0] ptr_next;
   logic              gnt_valid;
   logic [ADDR_W-1:0] gnt_idx;
   logic              slot_free;
   logic              grant;
   logic              drop_pulse_q;
   logic [DROP_W-1:0] drop_count_q;
   logic [SUM_W-1:0]  drop_sum;
   logic [DROP_W-1:0] drop_next;

   rr_priority_select #(
      .NUM_CH (NUM_CH),
      .ADDR_W (ADDR_W)
   ) u_select (
      .req       (pending_q),
      .ptr       (rr_ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      slot_free = !out_valid_q || aer.aer_ready;
      grant     = enable && slot_free && gnt_valid;
      gnt_mask  = '0;
      if (grant) begin
         gnt_mask[gnt_idx] = 1'b1;
      end
      spike_en = enable ? spike_in : '0;
      // A spike only drops when its channel still holds an event that is not leaving this cycle.
      drop_vec  = spike_en & pending_q & ~gnt_mask;
      pending_d = enable ? ((pending_q & ~gnt_mask) | spike_en) : '0;
      ptr_next  = (gnt_idx == ADDR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      drop_sum  = SUM_W'(drop_count_q) + SUM_W'($countones(drop_vec));
      drop_next = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[DROP_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q    <= '0;
         out_valid_q  <= 1'b0;
         out_addr_q   <= '0;
         rr_ptr_q     <= '0;
         drop_pulse_q <= 1'b0;
         drop_count_q <= '0;
      end else begin
         pending_q    <= pending_d;
         drop_pulse_q <= |drop_vec;
         drop_count_q <= drop_next;
         if (grant) begin
            out_valid_q <= 1'b1;
            out_addr_q  <= gnt_idx;
            rr_ptr_q    <= ptr_next;
         end else if (aer.aer_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign aer.aer_valid = out_valid_q;
   assign aer.aer_addr  = out_addr_q;
   assign drop_pulse    = drop_pulse_q;
   assign drop_count    = drop_count_q;
   assign busy          = (|pending_q) | out_valid_q;

endmodule

// File: tb/tb_spike_aer_arbiter.sv
// Bench for spike_aer_arbiter: directed scenarios then random traffic, checked
// against a cycle-level reference model and an expected-event scoreboard.
module tb_spike_aer_arbiter;
   import snn_pkg::*;

   localparam int NUM_CH = 8;
   localparam int ADDR_W = 3;
   localparam int DROP_W = 16;
   localparam int SAT_W  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic              aer_ready;
   logic [NUM_CH-1:0] spike_in;
   logic              drop_pulse;
   logic              busy;
   logic [DROP_W-1:0] drop_count;
   logic              drop_pulse_s;
   logic              busy_s;
   logic [SAT_W-1:0]  drop_count_s;

   spike_aer_arbiter_if #(.ADDR_W(ADDR_W)) aer_if ();
   spike_aer_arbiter_if #(.ADDR_W(ADDR_W)) aer_if_s ();

   assign aer_if.aer_ready   = aer_ready;
   assign aer_if_s.aer_ready = aer_ready;

   spike_aer_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DROP_W(DROP_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .spike_in   (spike_in),
      .aer        (aer_if.master),
      .drop_pulse (drop_pulse),
      .drop_count (drop_count),
      .busy       (busy)
   );

   spike_aer_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DROP_W(SAT_W)) dut_sat (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .spike_in   (spike_in),
      .aer        (aer_if_s.master),
      .drop_pulse (drop_pulse_s),
      .drop_count (drop_count_s),
      .busy       (busy_s)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit                m_pend [NUM_CH];
   int                m_ptr;
   bit                m_valid;
   int                m_addr;
   bit                m_pulse;
   int                m_drops;
   int                m_drops_s;
   bit                check_on = 1'b0;
   logic [ADDR_W-1:0] exp_q[$];
   int                n_checks = 0;
   int                n_pass = 0;

   always @(posedge clk) begin : ref_model
      int granted;
      int ndrop;
      if (!rst_n) begin
         foreach (m_pend[i]) m_pend[i] = 1'b0;
         m_ptr     = 0;
         m_valid   = 1'b0;
         m_addr    = 0;
         m_pulse   = 1'b0;
         m_drops   = 0;
         m_drops_s = 0;
         exp_q.delete();
         check_on  = 1'b1;
      end else begin
         granted = -1;
         if (enable && (!m_valid || aer_ready)) begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (granted < 0 && m_pend[(m_ptr + k) % NUM_CH]) granted = (m_ptr + k) % NUM_CH;
            end
         end
         if (granted >= 0) begin
            m_valid = 1'b1;
            m_addr  = granted;
            m_ptr   = (granted + 1) % NUM_CH;
            m_pend[granted] = 1'b0;
            exp_q.push_back(ADDR_W'(granted));
         end else if (aer_ready) begin
            m_valid = 1'b0;
         end
         ndrop = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (!enable) m_pend[i] = 1'b0;
            else if (spike_in[i]) begin
               if (m_pend[i]) ndrop++;
               else m_pend[i] = 1'b1;
            end
         end
         m_pulse   = (ndrop > 0);
         m_drops   = (m_drops + ndrop > 65535) ? 65535 : m_drops + ndrop;
         m_drops_s = (m_drops_s + ndrop > 3) ? 3 : m_drops_s + ndrop;
      end
   end

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (check_on) begin
         bit any_pend;
         any_pend = 1'b0;
         foreach (m_pend[i]) any_pend |= m_pend[i];
         check("aer_valid", int'(aer_if.aer_valid), int'(m_valid));
         if (m_valid) check("aer_addr", int'(aer_if.aer_addr), m_addr);
         check("busy", int'(busy), int'(any_pend | m_valid));
         check("drop_pulse", int'(drop_pulse), int'(m_pulse));
         check("drop_count", int'(drop_count), m_drops);
         check("drop_count_sat", int'(drop_count_s), m_drops_s);
         if (aer_if.aer_valid && aer_ready && rst_n) begin
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else check("sb_addr", int'(aer_if.aer_addr), int'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic step(input bit e, input logic [NUM_CH-1:0] s, input bit r);
      enable    = e;
      spike_in  = s;
      aer_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input bit e, input bit r);
      repeat (n) step(e, '0, r);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n     = 1'b0;
      enable    = 1'b0;
      spike_in  = '0;
      aer_ready = 1'b0;
      idle(3, 1'b0, 1'b0);
      rst_n = 1'b1;

      // single spike on ch2
      step(1'b1, 8'h04, 1'b1);
      idle(5, 1'b1, 1'b1);
      // full burst, then re-point rr via lone ch2 grant, then burst again
      step(1'b1, 8'hFF, 1'b1);
      idle(10, 1'b1, 1'b1);
      step(1'b1, 8'h04, 1'b1);
      idle(4, 1'b1, 1'b1);
      step(1'b1, 8'hFF, 1'b1);
      idle(10, 1'b1, 1'b1);
      // backpressure with ch1 and ch5
      step(1'b1, 8'h22, 1'b0);
      idle(10, 1'b1, 1'b0);
      idle(4, 1'b1, 1'b1);
      // repeated ch0 spikes while pending and stalled
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      repeat (5) step(1'b1, 8'h01, 1'b0);
      idle(6, 1'b1, 1'b1);
      // same-cycle regrant on ch4
      step(1'b1, 8'h10, 1'b1);
      step(1'b1, 8'h10, 1'b1);
      idle(5, 1'b1, 1'b1);
      // enable drop while ch1 is held and ch2/ch6 pending
      step(1'b1, 8'h02, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'h44, 1'b0);
      step(1'b1, 8'h00, 1'b0);
      idle(3, 1'b0, 1'b0);
      idle(3, 1'b0, 1'b1);
      idle(3, 1'b1, 1'b1);
      // reset while an event is held; ch7/ch1 order then shows rr restarted at 0
      step(1'b1, 8'h08, 1'b0);
      idle(3, 1'b1, 1'b0);
      rst_n = 1'b0;
      step(1'b1, 8'h00, 1'b0);
      rst_n = 1'b1;
      idle(3, 1'b1, 1'b1);
      step(1'b1, 8'h82, 1'b1);
      idle(4, 1'b1, 1'b1);

      // random traffic
      repeat (3000) begin
         logic [NUM_CH-1:0] s;
         bit dense;
         dense = ($urandom_range(0, 3) == 0);
         s = NUM_CH'($urandom);
         if (!dense) s = s & NUM_CH'($urandom) & NUM_CH'($urandom);
         rst_n = ($urandom_range(0, 499) != 0);
         step($urandom_range(0, 15) != 0, s, $urandom_range(0, 3) != 0);
      end
      rst_n = 1'b1;
      idle(20, 1'b1, 1'b1);
      check("sb_drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/spike_aer_arbiter.md
Name: spike_aer_arbiter

Overview:
- Merges the single-cycle spike trains of NUM_CH spike encoders onto one address-event (AER) output stream with a valid/ready handshake.
- Each channel holds at most one pending event. A round-robin scheduler grants one channel per cycle into a single output register.
- Sits between the encoder bank and the downstream neuron/routing fabric. Spikes that cannot be buffered are counted, not silently lost.

Parameters:
- NUM_CH, 8, number of spike input channels (>=2).
- ADDR_W, $clog2(NUM_CH), width of the emitted channel address.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- enable  in  1  1 = accept spikes and grant; 0 = flush pending, no new grants.
- spike_in  in  NUM_CH  per-channel spike pulses, one clock wide, from the encoders.
- aer_valid  out  1  output event valid.
- aer_addr  out  ADDR_W  channel index of the output event.
- aer_ready  in  1  downstream accepts the event when aer_valid & aer_ready.
- drop_pulse  out  1  one-cycle pulse: at least one spike dropped this cycle.
- drop_count  out  DROP_W  saturating count of dropped spikes.
- busy  out  1  high if any pending bit is set or aer_valid=1.

Behaviour:
- Reset (rst_n=0 at posedge): all outputs are reset to 0: aer_valid, aer_addr, drop_pulse, drop_count, busy. pending[] cleared; rr_ptr=0. Reset mid-handshake discards the event.
- Output slot "free" when aer_valid=0 or (aer_valid & aer_ready).
- Grant: when enable=1, the slot is free and pending!=0, select the first set pending bit searching rr_ptr, rr_ptr+1, ..., NUM_CH-1, 0, ..., rr_ptr-1.
  - Load aer_addr=idx, aer_valid=1.
  - Clear pending[idx].
  - rr_ptr = (idx+1) mod NUM_CH (wraps NUM_CH-1 -> 0).
- No grant and handshake completes: aer_valid -> 0. aer_valid holds with stable aer_addr until accepted (no retraction).
- Pending set: spike_in[i]=1 & enable=1 sets pending[i] next cycle.
  - If pending[i] is already 1 and channel i is not granted this cycle, the spike is dropped.
  - If channel i is granted in the same cycle, pending[i] stays 1 (the new spike is kept, not dropped).
  - A spike on the channel currently in the output register is not a drop.
- Drops: drop_pulse=1 in the cycle after any drop. drop_count increments by the number of channels dropping that cycle (popcount) and saturates at 2^DROP_W-1.
- Latency: spike sampled at edge k -> pending at k -> aer_valid at edge k+1 (2-cycle min), assuming the slot is free.
- Throughput: 1 event/cycle with aer_ready held high.
- enable=0:
  - spike_in ignored (no drops counted).
  - pending[] cleared.
  - No new grants; an already valid event still completes its handshake.
  - rr_ptr and drop_count retained.
- busy = |pending | aer_valid (registered-state derived).

Decomposition:
- Shared package snn_pkg: function clog2-safe ADDR_W helper; constant DROP_W default; aer event struct/typedef {valid, addr}.
- One sub-module rr_priority_select: combinational round-robin find-first (inputs req[NUM_CH], ptr[ADDR_W]; outputs gnt_valid, gnt_idx). All state stays in spike_aer_arbiter.

Test Plan:
- Single spike: enable=1, aer_ready=1, spike_in=8'h04 for one cycle -> aer_valid=1 with aer_addr=2 exactly 2 cycles later for 1 cycle; busy returns 0; drop_count=0.
- Round-robin fairness: spike_in=8'hFF one cycle, aer_ready=1 -> addresses 0,1,2,...,7 on consecutive cycles. A second 8'hFF burst after rr_ptr=3 is set by a lone grant on ch2 -> order 3,4,5,6,7,0,1,2.
- Backpressure: aer_ready=0, spikes on ch1 and ch5 -> aer_valid=1, aer_addr=1 held stable for 10 cycles; aer_ready=1 -> next cycle aer_addr=5; no drops.
- Drop/saturation: aer_ready=0, ch0 spikes 3 times while pending -> drop_pulse on 2 cycles, drop_count=2. With DROP_W=2, 5 drops -> drop_count stays 3.
- Same-cycle regrant: aer_ready=1, spike on ch4 at the cycle ch4 is granted -> two ch4 events emitted, drop_count unchanged.
- Enable/reset mid-operation: pending on ch2, ch6 and valid event ch1, aer_ready=0, then enable=0 -> ch1 held until accepted, ch2/ch6 never emitted. Asserting rst_n=0 while aer_valid=1 -> aer_valid=0 next edge, rr_ptr=0.
